// File: rtl/pc_sequencer_if.sv
// Fetch-redirect bus between the pipeline control logic and pc_sequencer.
// The slave modport is the sequencer side; master is the core/environment side.
interface pc_sequencer_if #(
    parameter int PC_W = 9
);
    logic            PcSel;
    logic [31:0]     BrPC;
    logic            flag_halt;
    logic            stall_req;
    logic [PC_W-1:0] Cur_PC;
    logic            PC_En;
    logic            IF_ID_En;
    logic            IF_ID_Flush;
    logic            ID_EX_Flush;
    logic            halted;
    logic            fault;
    logic [31:0]     taken_cnt;
    logic [31:0]     stall_cnt;

    modport master (
        output PcSel, BrPC, flag_halt, stall_req,
        input  Cur_PC, PC_En, IF_ID_En, IF_ID_Flush, ID_EX_Flush,
               halted, fault, taken_cnt, stall_cnt
    );

    modport slave (
        input  PcSel, BrPC, flag_halt, stall_req,
        output Cur_PC, PC_En, IF_ID_En, IF_ID_Flush, ID_EX_Flush,
               halted, fault, taken_cnt, stall_cnt
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter owner with run/drain/halt/fault sequencing for the 5-stage core.
// Define PC_SEQ_STATS_EN to build the taken-redirect and stall-cycle counters.
module pc_sequencer #(
    parameter int PC_W      = 9,
    parameter int DRAIN_CYC = 3
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.slave  bus
);
    localparam int CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED, S_FAULT} state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            bad_tgt;
    logic            pc_en, ifid_en, ifid_fl, idex_fl;

    // Redirect target must be word aligned and fit inside the PC width.
    assign bad_tgt = bus.PcSel && ((bus.BrPC[1:0] != 2'b00) || ((bus.BrPC >> PC_W) != '0));

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        pc_en   = 1'b0;
        ifid_en = 1'b0;
        ifid_fl = 1'b0;
        idex_fl = 1'b0;
        case (state_q)
            S_RUN: begin
                if (bus.PcSel) begin
                    ifid_fl = 1'b1;
                    idex_fl = 1'b1;
                    if (bad_tgt) begin
                        state_d = S_FAULT;
                    end else begin
                        pc_d    = bus.BrPC[PC_W-1:0];
                        pc_en   = 1'b1;
                        ifid_en = 1'b1;
                    end
                end else if (bus.flag_halt) begin
                    state_d = S_DRAIN;
                    cnt_d   = CNT_W'(DRAIN_CYC - 1);
                    ifid_fl = 1'b1;
                end else if (bus.stall_req) begin
                    idex_fl = 1'b1;
                end else begin
                    pc_d    = pc_q + PC_W'(4);
                    pc_en   = 1'b1;
                    ifid_en = 1'b1;
                end
            end
            S_DRAIN: begin
                ifid_fl = 1'b1;
                if (bus.PcSel) begin
                    // Older branch resolving during drain means the halt was wrong path.
                    idex_fl = 1'b1;
                    if (bad_tgt) begin
                        state_d = S_FAULT;
                    end else begin
                        state_d = S_RUN;
                        pc_d    = bus.BrPC[PC_W-1:0];
                        cnt_d   = '0;
                        pc_en   = 1'b1;
                        ifid_en = 1'b1;
                    end
                end else if (cnt_q == '0) begin
                    state_d = S_HALTED;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                ifid_fl = 1'b1;
                idex_fl = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RUN;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.Cur_PC      = pc_q;
    assign bus.PC_En       = pc_en;
    assign bus.IF_ID_En    = ifid_en;
    assign bus.IF_ID_Flush = ifid_fl;
    assign bus.ID_EX_Flush = idex_fl;
    assign bus.halted      = (state_q == S_HALTED);
    assign bus.fault       = (state_q == S_FAULT);

`ifdef PC_SEQ_STATS_EN
    logic [31:0] taken_q, stall_q;
    logic        take_ev, stall_ev;

    assign take_ev  = ((state_q == S_RUN) || (state_q == S_DRAIN)) && bus.PcSel && !bad_tgt;
    assign stall_ev = (state_q == S_RUN) && !bus.PcSel && !bus.flag_halt && bus.stall_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            taken_q <= '0;
            stall_q <= '0;
        end else begin
            if (take_ev)  taken_q <= taken_q + 32'd1;
            if (stall_ev) stall_q <= stall_q + 32'd1;
        end
    end

    assign bus.taken_cnt = taken_q;
    assign bus.stall_cnt = stall_q;
`else
    assign bus.taken_cnt = '0;
    assign bus.stall_cnt = '0;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random traffic
// compared against a cycle-level behavioural model of the fetch sequencing rules.
module tb_pc_sequencer;
    localparam int PC_W      = 9;
    localparam int DRAIN_CYC = 3;
    localparam int VW        = 6 + PC_W + 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pc_sequencer_if #(.PC_W(PC_W)) bus ();

    pc_sequencer #(.PC_W(PC_W), .DRAIN_CYC(DRAIN_CYC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int unsigned nchecks = 0;
    int unsigned npass   = 0;

    // Behavioural model: stop kind 0=running, 1=halted, 2=fault; halt_age<0 means no halt pending.
    int unsigned m_pc     = 0;
    int          m_stop   = 0;
    int          m_age    = -1;
    int unsigned m_taken  = 0;
    int unsigned m_stalls = 0;

    // Observed/expected control bits: {PC_En, IF_ID_En, IF_ID_Flush, ID_EX_Flush, halted, fault}
    logic [5:0]      obs_ctl, exp_ctl;
    logic [PC_W-1:0] obs_pc_pre, obs_pc;
    logic [31:0]     obs_taken, obs_stall;

    function automatic logic is_bad(input logic [31:0] br);
        return (br % 4 != 0) || (br >= (32'd1 << PC_W));
    endfunction

    function automatic logic [5:0] model_ctl(input logic sel, input logic [31:0] br,
                                             input logic hlt, input logic stl);
        if (m_stop == 1) return 6'b001110;
        if (m_stop == 2) return 6'b001101;
        if (m_age >= 0) begin
            if (sel) return is_bad(br) ? 6'b001100 : 6'b111100;
            return 6'b001000;
        end
        if (sel)  return is_bad(br) ? 6'b001100 : 6'b111100;
        if (hlt)  return 6'b001000;
        if (stl)  return 6'b000100;
        return 6'b110000;
    endfunction

    task automatic model_update(input logic rst, input logic sel, input logic [31:0] br,
                                input logic hlt, input logic stl);
        if (rst) begin
            m_pc = 0; m_stop = 0; m_age = -1; m_taken = 0; m_stalls = 0;
        end else if (m_stop != 0) begin
            // absorbing
        end else if (sel) begin
            if (is_bad(br)) m_stop = 2;
            else begin
                m_pc = br; m_taken++;
            end
            m_age = -1;
        end else if (m_age >= 0) begin
            m_age++;
            if (m_age == DRAIN_CYC) m_stop = 1;
        end else if (hlt) begin
            m_age = 0;
        end else if (stl) begin
            m_stalls++;
        end else begin
            m_pc = (m_pc + 4) % (32'd1 << PC_W);
        end
    endtask

    function automatic logic [VW-1:0] exp_all();
        logic [31:0] t, s;
`ifdef PC_SEQ_STATS_EN
        t = m_taken; s = m_stalls;
`else
        t = '0; s = '0;
`endif
        return {exp_ctl, PC_W'(m_pc), t, s};
    endfunction

    function automatic logic [VW-1:0] obs_all();
        return {obs_ctl, obs_pc, obs_taken, obs_stall};
    endfunction

    function automatic logic [31:0] stat(input int unsigned v);
`ifdef PC_SEQ_STATS_EN
        return v;
`else
        return v & 32'd0;
`endif
    endfunction

    task automatic apply(input logic rst, input logic sel, input logic [31:0] br,
                         input logic hlt, input logic stl);
        reset = rst; bus.PcSel = sel; bus.BrPC = br; bus.flag_halt = hlt; bus.stall_req = stl;
        @(negedge clk);
        obs_ctl    = {bus.PC_En, bus.IF_ID_En, bus.IF_ID_Flush, bus.ID_EX_Flush, bus.halted, bus.fault};
        exp_ctl    = model_ctl(sel, br, hlt, stl);
        obs_pc_pre = bus.Cur_PC;
        @(posedge clk);
        model_update(rst, sel, br, hlt, stl);
        #1;
        obs_pc    = bus.Cur_PC;
        obs_taken = bus.taken_cnt;
        obs_stall = bus.stall_cnt;
    endtask

    task automatic idle(); apply(1'b0, 1'b0, 32'h0, 1'b0, 1'b0); endtask

    task automatic test_reset();
        logic [5:0] ctl;
        apply(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        reset = 1'b0;
        ctl = {bus.PC_En, bus.IF_ID_En, bus.IF_ID_Flush, bus.ID_EX_Flush, bus.halted, bus.fault};
        nchecks++;
        if ({obs_pc, obs_taken, obs_stall} !== {PC_W'(0), 64'h0})
            $display("FAIL reset_regs: got pc=%h taken=%h stall=%h want 0", obs_pc, obs_taken, obs_stall);
        else npass++;
        nchecks++;
        if (ctl !== 6'b110000) $display("FAIL reset_ctl: got %b want 110000", ctl);
        else npass++;
    endtask

    task automatic test_free_run();
        for (int i = 0; i < 4; i++) begin
            idle();
            nchecks++;
            if (obs_all() !== exp_all()) $display("FAIL free_run_model cyc%0d: got %h want %h", i, obs_all(), exp_all());
            else npass++;
            nchecks++;
            if (obs_pc !== PC_W'(4 * (i + 1)) || obs_ctl[3:2] !== 2'b00)
                $display("FAIL free_run_pc cyc%0d: got pc=%h fl=%b want pc=%h fl=00", i, obs_pc, obs_ctl[3:2], 4 * (i + 1));
            else npass++;
        end
    endtask

    task automatic test_redirect();
        for (int i = 0; i < 4; i++) idle();
        nchecks++;
        if (obs_pc !== PC_W'(32'h20)) $display("FAIL redirect_pre: got pc=%h want 020", obs_pc);
        else npass++;
        apply(1'b0, 1'b1, 32'h40, 1'b0, 1'b1);
        nchecks++;
        if (obs_ctl[3:2] !== 2'b11 || obs_pc !== PC_W'(32'h40))
            $display("FAIL redirect: got fl=%b pc=%h want fl=11 pc=040", obs_ctl[3:2], obs_pc);
        else npass++;
        nchecks++;
        if (obs_taken !== stat(1) || obs_stall !== stat(0))
            $display("FAIL redirect_stats: got taken=%0d stall=%0d want %0d/%0d", obs_taken, obs_stall, stat(1), stat(0));
        else npass++;
    endtask

    task automatic test_stall();
        apply(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) idle();
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
            nchecks++;
            if (obs_pc_pre !== PC_W'(32'h10) || obs_pc !== PC_W'(32'h10) || obs_ctl !== 6'b000100)
                $display("FAIL stall cyc%0d: got pc=%h/%h ctl=%b want 010/010 000100", i, obs_pc_pre, obs_pc, obs_ctl);
            else npass++;
        end
        idle();
        nchecks++;
        if (obs_pc !== PC_W'(32'h14) || obs_stall !== stat(2))
            $display("FAIL stall_resume: got pc=%h stall=%0d want 014 %0d", obs_pc, obs_stall, stat(2));
        else npass++;
    endtask

    task automatic test_halt();
        apply(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        idle(); idle();
        apply(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        nchecks++;
        if (obs_ctl !== 6'b001000) $display("FAIL halt_accept: got %b want 001000", obs_ctl);
        else npass++;
        for (int i = 1; i <= DRAIN_CYC; i++) begin
            apply(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
            nchecks++;
            if (obs_ctl !== 6'b001000 || obs_pc !== PC_W'(32'h8))
                $display("FAIL halt_drain T+%0d: got ctl=%b pc=%h want 001000 008", i, obs_ctl, obs_pc);
            else npass++;
        end
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 127) * 4, 1'b0, 1'($urandom_range(0, 1)));
            nchecks++;
            if (obs_ctl !== 6'b001110 || obs_all() !== exp_all())
                $display("FAIL halted cyc%0d: got %h want %h", i, obs_all(), exp_all());
            else npass++;
        end
    endtask

    task automatic test_halt_cancel();
        apply(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        idle();
        apply(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        idle();
        apply(1'b0, 1'b1, 32'h80, 1'b0, 1'b0);
        nchecks++;
        if (obs_ctl !== 6'b111100 || obs_pc !== PC_W'(32'h80))
            $display("FAIL halt_cancel: got ctl=%b pc=%h want 111100 080", obs_ctl, obs_pc);
        else npass++;
        for (int i = 0; i < 5; i++) begin
            idle();
            nchecks++;
            if (obs_ctl[1] !== 1'b0 || obs_all() !== exp_all())
                $display("FAIL cancel_run cyc%0d: got %h want %h", i, obs_all(), exp_all());
            else npass++;
        end
    endtask

    task automatic test_fault();
        logic [31:0] bads [2];
        logic [PC_W-1:0] frozen;
        bads[0] = 32'h42;
        bads[1] = 32'h400;
        for (int b = 0; b < 2; b++) begin
            apply(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
            idle(); idle();
            frozen = obs_pc;
            apply(1'b0, 1'b1, bads[b], 1'b0, 1'b0);
            nchecks++;
            if (obs_ctl !== 6'b001100 || obs_pc !== frozen)
                $display("FAIL fault_entry %h: got ctl=%b pc=%h want 001100 %h", bads[b], obs_ctl, obs_pc, frozen);
            else npass++;
            for (int i = 0; i < 3; i++) begin
                apply(1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 127) * 4,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                nchecks++;
                if (obs_ctl !== 6'b001101 || obs_pc !== frozen)
                    $display("FAIL fault_hold %h cyc%0d: got ctl=%b pc=%h want 001101 %h", bads[b], i, obs_ctl, obs_pc, frozen);
                else npass++;
            end
        end
    endtask

    task automatic test_wrap();
        apply(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 32'h1FC, 1'b0, 1'b0);
        idle();
        nchecks++;
        if (obs_pc_pre !== PC_W'(32'h1FC) || obs_pc !== PC_W'(0))
            $display("FAIL wrap: got %h->%h want 1fc->000", obs_pc_pre, obs_pc);
        else npass++;
    endtask

    task automatic test_reset_drain();
        logic [5:0] ctl;
        apply(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        idle();
        apply(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        idle();
        apply(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        reset = 1'b0;
        ctl = {bus.PC_En, bus.IF_ID_En, bus.IF_ID_Flush, bus.ID_EX_Flush, bus.halted, bus.fault};
        nchecks++;
        if (obs_pc !== PC_W'(0) || ctl !== 6'b110000)
            $display("FAIL reset_drain: got pc=%h ctl=%b want 000 110000", obs_pc, ctl);
        else npass++;
    endtask

    task automatic test_random();
        logic [31:0] br;
        apply(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            br = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 127) * 4 : $urandom;
            apply(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 4) == 0), br,
                  1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 3) == 0));
            nchecks++;
            if (obs_all() !== exp_all()) $display("FAIL random cyc%0d: got %h want %h", i, obs_all(), exp_all());
            else npass++;
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.PcSel = 1'b0; bus.BrPC = '0; bus.flag_halt = 1'b0; bus.stall_req = 1'b0;
        test_reset();
        test_free_run();
        test_redirect();
        test_stall();
        test_halt();
        test_halt_cancel();
        test_fault();
        test_wrap();
        test_reset_drain();
        test_random();
        $display("%0d/%0d checks passed", npass, nchecks);
        $finish;
    end
endmodule
